// File: rtl/serial_deframer_pkg.sv
// serial_deframer_pkg: line-coding constants and deframer state encoding shared by the
// serial transmitter and receiver.
package serial_deframer_pkg;

    localparam logic [7:0] COMMA_DEF      = 8'hBC;
    localparam int unsigned LOCK_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

endpackage

// File: rtl/serial_deframer.sv
// serial_deframer: finds byte alignment in an MSB-first bit stream from repeated COMMA
// characters, then reports each aligned byte with a one-cycle strobe.
module serial_deframer
    import serial_deframer_pkg::*;
#(
    parameter logic [7:0]  COMMA      = COMMA_DEF,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic       clk_8f,
    input  logic       reset_L,
    input  logic       in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       locked
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] ccnt_q, ccnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       strobe_q, strobe_d;
    logic       locked_q, locked_d;
    logic [7:0] word;
    logic       is_comma;
    logic [3:0] ccnt_inc;

    always_comb begin
        word     = {sr_q[6:0], in};
        is_comma = (word == COMMA);
        ccnt_inc = ccnt_q + 4'd1;
        sr_d     = word;
        state_d  = state_q;
        cnt_d    = cnt_q;
        ccnt_d   = ccnt_q;
        data_d   = data_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                cnt_d  = 3'd0;
                ccnt_d = is_comma ? 4'd1 : 4'd0;
                if (is_comma)
                    state_d = (LOCK_N == 4'd1) ? ST_LOCKED : ST_SYNC;
            end
            ST_SYNC: begin
                cnt_d = cnt_q + 3'd1;
                // Only commas landing exactly on the tentative boundary count toward lock.
                if (cnt_q == 3'd7) begin
                    if (is_comma) begin
                        ccnt_d  = ccnt_inc;
                        state_d = (ccnt_inc == LOCK_N) ? ST_LOCKED : ST_SYNC;
                    end else begin
                        state_d = ST_UNLOCKED;
                        ccnt_d  = 4'd0;
                        cnt_d   = 3'd0;
                    end
                end
            end
            ST_LOCKED: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    data_d   = word;
                    valid_d  = ~is_comma;
                    strobe_d = 1'b1;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= ST_UNLOCKED;
            sr_q     <= 8'h00;
            cnt_q    <= 3'd0;
            ccnt_q   <= 4'd0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            ccnt_q   <= ccnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            locked_q <= locked_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_serial_deframer.sv
// tb_serial_deframer: drives MSB-first bytes into serial_deframer and checks lock timing
// plus every strobed byte against a queue of expected {valid, data} records.
module tb_serial_deframer;
    import serial_deframer_pkg::*;

    logic       clk_8f  = 1'b0;
    logic       reset_L = 1'b0;
    logic       din     = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, byte_strobe, locked;

    int         tests = 0, fails = 0, edge_n = 0, strobe_edge = 0, lock_edge = 0;
    logic [8:0] sb[$];
    logic [7:0] hold_d = 8'h00;
    logic       hold_v = 1'b0;
    logic [7:0] bc = 8'hBC;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;
    vec_t vecs[8];

    always #5 clk_8f = ~clk_8f;

    serial_deframer dut (
        .clk_8f      (clk_8f),
        .reset_L     (reset_L),
        .in          (din),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .locked      (locked)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Every edge: a strobe must consume one expected record, otherwise outputs must hold.
    task automatic send_bit(input logic b);
        logic [8:0] e;
        din = b;
        @(posedge clk_8f);
        #1;
        edge_n++;
        if (byte_strobe === 1'b1) begin
            strobe_edge = edge_n;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, e[7:0]});
                check("valid_out", {31'd0, valid_out}, {31'd0, e[8]});
                hold_d = e[7:0];
                hold_v = e[8];
            end
        end else begin
            check("strobe_low", {31'd0, byte_strobe}, 32'd0);
            check("data_hold", {24'd0, data_out}, {24'd0, hold_d});
            check("valid_hold", {31'd0, valid_out}, {31'd0, hold_v});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic push, input logic [7:0] ed,
                             input logic ev);
        if (push) sb.push_back({ev, ed});
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, {24'd0, data_out}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
        check({tag, "_strobe"}, {31'd0, byte_strobe}, 32'd0);
        check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        din     = 1'b0;
        sb.delete();
        hold_d  = 8'h00;
        hold_v  = 1'b0;
        repeat (2) @(posedge clk_8f);
        #1;
        check_zero("reset");
        reset_L = 1'b1;
    endtask

    // Four aligned commas: locked must still be low after 31 edges and high after the 32nd.
    task automatic lock4();
        for (int k = 0; k < 3; k++) send_byte(bc, 1'b0, 8'h00, 1'b0);
        for (int i = 7; i >= 1; i--) send_bit(bc[i]);
        check("locked_before_32", {31'd0, locked}, 32'd0);
        send_bit(bc[0]);
        check("locked_at_32", {31'd0, locked}, 32'd1);
        lock_edge = edge_n;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 1'b1};
        vecs[1] = '{8'h3C, 8'h3C, 1'b1};
        vecs[2] = '{8'hBC, 8'hBC, 1'b0};
        vecs[3] = '{8'h0B, 8'h0B, 1'b1};
        vecs[4] = '{8'hC0, 8'hC0, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1};
        vecs[7] = '{8'h5A, 8'h5A, 1'b1};

        do_reset();
        lock4();
        send_byte(bc, 1'b1, 8'hBC, 1'b0);
        check("first_strobe_delay", strobe_edge - lock_edge, 32'd8);
        for (int v = 0; v < 8; v++)
            send_byte(vecs[v].din, 1'b1, vecs[v].exp_data, vecs[v].exp_valid);
        check("locked_stays", {31'd0, locked}, 32'd1);

        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        check_zero("async_reset");
        sb.delete();
        hold_d = 8'h00;
        hold_v = 1'b0;
        @(posedge clk_8f);
        #1;
        reset_L = 1'b1;
        lock4();
        send_byte(8'h5A, 1'b1, 8'h5A, 1'b1);

        do_reset();
        for (int k = 0; k < 3; k++) send_bit(1'($urandom_range(0, 1)));
        lock4();
        send_byte(8'h5A, 1'b1, 8'h5A, 1'b1);

        do_reset();
        send_byte(bc, 1'b0, 8'h00, 1'b0);
        send_byte(bc, 1'b0, 8'h00, 1'b0);
        send_byte(8'h12, 1'b0, 8'h00, 1'b0);
        check("unlocked_after_12", {31'd0, locked}, 32'd0);
        lock4();
        send_byte(8'hC3, 1'b1, 8'hC3, 1'b1);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
